// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Misses stall the CPU while the victim line is written back (if dirty) and the line is refilled.
module dcache_wb #(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(SETS);
    localparam int TB = ADDR_WIDTH - 2 - WB - IB;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t          state, state_next;
    logic [SETS-1:0] valid, dirty;
    logic [TB-1:0]   tag_mem  [SETS];
    logic [31:0]     data_mem [SETS*WORDS_PER_LINE];

    logic [WB-1:0]   req_word, beat;
    logic [IB-1:0]   req_idx, miss_idx;
    logic [TB-1:0]   req_tag, miss_tag;
    logic            hit, last_beat, access;
    logic            unused_addr_bits;

    assign req_word         = cpu_addr[2 +: WB];
    assign req_idx          = cpu_addr[2+WB +: IB];
    assign req_tag          = cpu_addr[ADDR_WIDTH-1 -: TB];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign last_beat = (beat == WB'(WORDS_PER_LINE - 1));
    assign access    = cpu_req && (state == IDLE);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output and the next state get a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cpu_rdata  = '0;
        cpu_stall  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        if (!cpu_we) cpu_rdata = data_mem[{req_idx, req_word}];
                    end else begin
                        cpu_stall  = 1'b1;
                        state_next = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[miss_idx], miss_idx, beat, 2'b00};
                mem_wdata = data_mem[{miss_idx, beat}];
                if (mem_ready && last_beat) state_next = REFILL;
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {miss_tag, miss_idx, beat, 2'b00};
                if (mem_ready && last_beat) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line bookkeeping; a line is invalid for the whole refill so a reset mid-miss leaves it unusable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= '0;
            dirty    <= '0;
            beat     <= '0;
            miss_idx <= '0;
            miss_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (hit) begin
                            if (cpu_we) dirty[req_idx] <= 1'b1;
                        end else begin
                            miss_idx <= req_idx;
                            miss_tag <= req_tag;
                            if (!(valid[req_idx] && dirty[req_idx])) valid[req_idx] <= 1'b0;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            dirty[miss_idx] <= 1'b0;
                            valid[miss_idx] <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[miss_idx] <= 1'b1;
                            dirty[miss_idx] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits guard them, and they stay RAM-mappable.
    always_ff @(posedge clk) begin
        if (access && hit && cpu_we) data_mem[{req_idx, req_word}] <= cpu_wdata;
        if (state == REFILL && mem_ready) begin
            data_mem[{miss_idx, beat}] <= mem_rdata;
            if (last_beat) tag_mem[miss_idx] <= miss_tag;
        end
    end
endmodule
